// File: rtl/click_pkg.sv
// Shared types and elaboration helpers for the click conditioner.
package click_pkg;

    typedef enum logic [1:0] {IDLE, PRESSED, LONG} click_state_t;

    // True when a counter of `width` bits can hold `value` without wrapping.
    function automatic bit counter_fits(int unsigned value, int unsigned width);
        return (width >= 32) || (value < (32'd1 << width));
    endfunction

endpackage

// File: rtl/click_filter.sv
// Two-flop synchronizer plus debounce filter for the raw push-button.
// `flip` is high in the cycle before `held` toggles so the FSM can strobe on the same edge.
module click_filter #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic held,
    output logic flip
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             btn_s;
    logic [CNT_W-1:0] db_cnt;

    assign btn_s = sync2;
    assign flip  = (btn_s != held) && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db_cnt <= '0;
            held   <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            if ((btn_s == held) || flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (flip) begin
                held <= ~held;
            end
        end
    end

endmodule

// File: rtl/click_conditioner.sv
// Turns the bouncing button into single-cycle press/repeat strobes with long-press detection.
module click_conditioner
    import click_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned LONG_CYCLES     = 64,
    parameter int unsigned REPEAT_CYCLES   = 16,
    parameter bit          REPEAT_EN       = 1'b1,
    parameter int unsigned CNT_W           = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic valid,
    output logic held,
    output logic long_press
);

    localparam bit CNT_OK = counter_fits(LONG_CYCLES, CNT_W) &&
                            counter_fits(REPEAT_CYCLES, CNT_W) &&
                            counter_fits(DEBOUNCE_CYCLES, CNT_W);

    if (!CNT_OK) begin : g_bad_cnt_w
        $error("click_conditioner: CNT_W too small for the configured cycle counts");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    click_state_t     state;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             flip;
    logic             rise;
    logic             fall;

    click_filter #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_filter (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .held  (held),
        .flip  (flip)
    );

    assign rise = flip & ~held;
    assign fall = flip & held;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            rep_cnt    <= '0;
            valid      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            valid      <= 1'b0;
            long_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= PRESSED;
                        valid    <= 1'b1;
                        hold_cnt <= '0;
                    end
                end
                PRESSED: begin
                    // Release wins over a coincident terminal count.
                    if (fall) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                    end else if (hold_cnt == LONG_LAST) begin
                        state      <= LONG;
                        long_press <= 1'b1;
                        valid      <= REPEAT_EN;
                        hold_cnt   <= '0;
                        rep_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state   <= IDLE;
                        rep_cnt <= '0;
                    end else if (rep_cnt == REP_LAST) begin
                        valid   <= REPEAT_EN;
                        rep_cnt <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_click_conditioner.sv
// Directed bench: DEBOUNCE=4, LONG=20, REPEAT=8, with one auto-repeat and one non-repeat instance.
module tb_click_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic button = 1'b0;
    logic valid, held, long_press;
    logic valid_nr, held_nr, long_nr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    click_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .REPEAT_EN      (1'b1),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .valid     (valid),
        .held      (held),
        .long_press(long_press)
    );

    click_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .REPEAT_CYCLES  (8),
        .REPEAT_EN      (1'b0),
        .CNT_W          (8)
    ) dut_nr (
        .clk       (clk),
        .rst       (rst),
        .button    (button),
        .valid     (valid_nr),
        .held      (held_nr),
        .long_press(long_nr)
    );

    // Inputs change and outputs are sampled at the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        button = 1'b0;
        repeat (30) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, held, long_press, valid_nr, held_nr, long_nr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_async: outputs=%b required=000000",
                     {valid, held, long_press, valid_nr, held_nr, long_nr});
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({valid, held, long_press, valid_nr, held_nr, long_nr} !== 6'b0) begin
            errors++;
            $display("FAIL reset_idle: outputs=%b required=000000",
                     {valid, held, long_press, valid_nr, held_nr, long_nr});
        end
    endtask

    task automatic test_clean_press();
        int hcnt = 0;
        button = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            checks++;
            if (valid !== (t == 6)) begin
                errors++;
                $display("FAIL clean_valid t=%0d: got %b required %b", t, valid, (t == 6));
            end
            checks++;
            if (long_press !== 1'b0) begin
                errors++;
                $display("FAIL clean_long t=%0d: got %b required 0", t, long_press);
            end
            if (held === 1'b1) hcnt++;
            if (t == 15) button = 1'b0;
        end
        checks++;
        if (hcnt != 15) begin
            errors++;
            $display("FAIL clean_held_len: got %0d cycles required 15", hcnt);
        end
        settle();
    endtask

    task automatic test_bounce();
        for (int t = 1; t <= 6; t++) begin
            button = t[0];
            tick();
            checks++;
            if (valid !== 1'b0 || held !== 1'b0) begin
                errors++;
                $display("FAIL bounce_quiet t=%0d: valid=%b held=%b required 0 0", t, valid, held);
            end
        end
        button = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            checks++;
            if (valid !== (t == 6)) begin
                errors++;
                $display("FAIL bounce_valid t=%0d: got %b required %b", t, valid, (t == 6));
            end
        end
        settle();
    endtask

    task automatic test_glitch();
        button = 1'b1;
        for (int t = 1; t <= 15; t++) begin
            tick();
            if (t == 3) button = 1'b0;
            checks++;
            if (valid !== 1'b0 || held !== 1'b0) begin
                errors++;
                $display("FAIL glitch t=%0d: valid=%b held=%b required 0 0", t, valid, held);
            end
        end
        settle();
    endtask

    // rep selects which instance is checked: 1 = auto-repeat, 0 = repeat disabled.
    task automatic test_long_press(input bit rep);
        logic v, l, h, ev, eh;
        button = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            v = rep ? valid : valid_nr;
            checks++;
            if (v !== (t == 6)) begin
                errors++;
                $display("FAIL long_press_valid rep=%0d t=%0d: got %b required %b",
                         rep, t, v, (t == 6));
            end
        end
        for (int t = 1; t <= 70; t++) begin
            tick();
            v  = rep ? valid : valid_nr;
            l  = rep ? long_press : long_nr;
            h  = rep ? held : held_nr;
            ev = rep && (t == 20 || t == 28 || t == 36 || t == 44 || t == 52);
            eh = (t < 56);
            checks++;
            if (v !== ev) begin
                errors++;
                $display("FAIL long_valid rep=%0d +%0d: got %b required %b", rep, t, v, ev);
            end
            checks++;
            if (l !== (t == 20)) begin
                errors++;
                $display("FAIL long_strobe rep=%0d +%0d: got %b required %b", rep, t, l, (t == 20));
            end
            checks++;
            if (h !== eh) begin
                errors++;
                $display("FAIL long_held rep=%0d +%0d: got %b required %b", rep, t, h, eh);
            end
            if (t == 50) button = 1'b0;
        end
        settle();
    endtask

    task automatic test_reset_mid_press();
        int vk = 0;
        int vcount = 0;
        button = 1'b1;
        repeat (6) tick();
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_press: valid got %b required 1", valid);
        end
        repeat (12) tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({valid, held, long_press, valid_nr, held_nr, long_nr} !== 6'b0) begin
            errors++;
            $display("FAIL midrst_async: outputs=%b required=000000",
                     {valid, held, long_press, valid_nr, held_nr, long_nr});
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k <= 10 && valid === 1'b1) begin
                vcount++;
                if (vk == 0) vk = k;
            end
            checks++;
            if (long_press !== (vk != 0 && k == vk + 20)) begin
                errors++;
                $display("FAIL midrst_long k=%0d: got %b required %b",
                         k, long_press, (vk != 0 && k == vk + 20));
            end
        end
        checks++;
        if (vcount != 1 || vk < 5 || vk > 6) begin
            errors++;
            $display("FAIL midrst_valid: count=%0d at k=%0d required one at k=5..6", vcount, vk);
        end
        settle();
    endtask

    initial begin
        #1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_long_press(1'b1);
        test_long_press(1'b0);
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
